// File: rtl/smbm_pkg.sv
// Shared opcode/status encodings and default sizing for the sorted multi-metric manager.
package smbm_pkg;

  typedef enum logic [1:0] {
    OP_ADD       = 2'd0,
    OP_DEL       = 2'd1,
    OP_READ_FILT = 2'd2,
    OP_READ_ALL  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK           = 2'd0,
    ST_ERR_FULL     = 2'd1,
    ST_ERR_DUP      = 2'd2,
    ST_ERR_NOTFOUND = 2'd3
  } status_e;

  localparam int unsigned DEF_ENTRIES     = 256;
  localparam int unsigned DEF_ID_W        = 8;
  localparam int unsigned DEF_NUM_METRICS = 2;
  localparam int unsigned DEF_METRIC_W    = 8;

endpackage

// File: rtl/smbm_param_priority_encode_log.sv
// Lowest-set-bit priority encoder; valid is low when no bit is set.
module priority_encode_log #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned LOG_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] decode,
  output logic [LOG_W-1:0] encode,
  output logic             valid
);

  always_comb begin
    encode = '0;
    valid  = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (decode[i] && !valid) begin
        encode = LOG_W'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/smbm_param.sv
// Sorted multi-metric bookkeeping: one ID-sorted list plus one value-sorted list per metric,
// served by a three-phase IDLE/EVAL/COMMIT request engine.
module smbm_param
  import smbm_pkg::*;
#(
  parameter int unsigned ENTRIES     = DEF_ENTRIES,
  parameter int unsigned ID_W        = DEF_ID_W,
  parameter int unsigned NUM_METRICS = DEF_NUM_METRICS,
  parameter int unsigned METRIC_W    = DEF_METRIC_W,
  parameter int unsigned MSEL_W      = (NUM_METRICS > 1) ? $clog2(NUM_METRICS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [1:0]                             req_op,
  input  logic [ID_W-1:0]                        req_id,
  input  logic [NUM_METRICS*METRIC_W-1:0]        req_metric,
  input  logic [2**ID_W-1:0]                     req_mask,
  input  logic [MSEL_W-1:0]                      req_msel,
  output logic                                   resp_valid,
  output logic [1:0]                             resp_status,
  output logic [$clog2(ENTRIES):0]               count,
  output logic [ENTRIES*(1+ID_W+METRIC_W)-1:0]   out_list
);

  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned SLOT_W = 1 + ID_W + METRIC_W;
  localparam int unsigned NL     = NUM_METRICS + 1;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_COMMIT} state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } id_ent_t;

  typedef struct packed {
    logic                valid;
    logic [ID_W-1:0]     id;
    logic [METRIC_W-1:0] val;
  } met_ent_t;

  state_e state_q, state_d;

  id_ent_t  id_list  [ENTRIES];
  met_ent_t met_list [NUM_METRICS][ENTRIES];

  op_e                             op_q;
  logic [ID_W-1:0]                 id_q;
  logic [NUM_METRICS*METRIC_W-1:0] metric_q;
  logic [2**ID_W-1:0]              mask_q;
  logic [MSEL_W-1:0]               msel_q;

  // Index 0 is the ID list, index m+1 is metric list m.
  logic [ENTRIES-1:0] gt        [NL];
  logic [ENTRIES-1:0] hit       [NL];
  logic [IDX_W-1:0]   enc       [NL];
  logic [NL-1:0]      enc_any;
  logic [IDX_W-1:0]   ins_idx_q [NL];
  logic [ENTRIES-1:0] hit_q     [NL];
  logic [ENTRIES-1:0] after_hit [NL];
  logic               found_q;
  logic               full_q;

  always_comb begin
    gt  = '{default: '0};
    hit = '{default: '0};
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      gt[0][i]  = !id_list[i].valid || (id_list[i].id > id_q);
      hit[0][i] = id_list[i].valid && (id_list[i].id == id_q);
      for (int unsigned m = 0; m < NUM_METRICS; m++) begin
        gt[m+1][i]  = !met_list[m][i].valid ||
                      (met_list[m][i].val > metric_q[m*METRIC_W +: METRIC_W]);
        hit[m+1][i] = met_list[m][i].valid && (met_list[m][i].id == id_q);
      end
    end
  end

  for (genvar l = 0; l < NL; l++) begin : g_enc
    priority_encode_log #(.WIDTH(ENTRIES)) u_enc (
      .decode (gt[l]),
      .encode (enc[l]),
      .valid  (enc_any[l])
    );
  end

  // Slots at or above the matched slot pull from the slot above on delete.
  always_comb begin
    logic acc;
    after_hit = '{default: '0};
    for (int unsigned l = 0; l < NL; l++) begin
      acc = 1'b0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        acc = acc | hit_q[l][i];
        after_hit[l][i] = acc;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_EVAL;
      end
      S_EVAL:   state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      id_q        <= '0;
      metric_q    <= '0;
      mask_q      <= '0;
      msel_q      <= '0;
      found_q     <= 1'b0;
      full_q      <= 1'b0;
      ins_idx_q   <= '{default: '0};
      hit_q       <= '{default: '0};
      id_list     <= '{default: '0};
      met_list    <= '{default: '{default: '0}};
      count       <= '0;
      out_list    <= '0;
      resp_valid  <= 1'b0;
      resp_status <= '0;
    end else begin
      state_q    <= state_d;
      resp_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q     <= op_e'(req_op);
            id_q     <= req_id;
            metric_q <= req_metric;
            mask_q   <= req_mask;
            msel_q   <= req_msel;
          end
        end
        S_EVAL: begin
          found_q <= |hit[0];
          full_q  <= (count == CNT_W'(ENTRIES)) || !(&enc_any);
          for (int unsigned l = 0; l < NL; l++) begin
            ins_idx_q[l] <= enc[l];
            hit_q[l]     <= hit[l];
          end
        end
        S_COMMIT: begin
          resp_valid  <= 1'b1;
          resp_status <= ST_OK;
          case (op_q)
            OP_ADD: begin
              if (found_q) begin
                resp_status <= ST_ERR_DUP;
              end else if (full_q) begin
                resp_status <= ST_ERR_FULL;
              end else begin
                for (int unsigned i = 1; i < ENTRIES; i++)
                  if (i > 32'(ins_idx_q[0])) id_list[i] <= id_list[i-1];
                id_list[ins_idx_q[0]] <= {1'b1, id_q};
                for (int unsigned m = 0; m < NUM_METRICS; m++) begin
                  for (int unsigned i = 1; i < ENTRIES; i++)
                    if (i > 32'(ins_idx_q[m+1])) met_list[m][i] <= met_list[m][i-1];
                  met_list[m][ins_idx_q[m+1]] <= {1'b1, id_q, metric_q[m*METRIC_W +: METRIC_W]};
                end
                count <= count + CNT_W'(1);
              end
            end
            OP_DEL: begin
              if (!found_q) begin
                resp_status <= ST_ERR_NOTFOUND;
              end else begin
                for (int unsigned i = 0; i < ENTRIES - 1; i++)
                  if (after_hit[0][i]) id_list[i] <= id_list[i+1];
                if (after_hit[0][ENTRIES-1]) id_list[ENTRIES-1] <= '0;
                for (int unsigned m = 0; m < NUM_METRICS; m++) begin
                  for (int unsigned i = 0; i < ENTRIES - 1; i++)
                    if (after_hit[m+1][i]) met_list[m][i] <= met_list[m][i+1];
                  if (after_hit[m+1][ENTRIES-1]) met_list[m][ENTRIES-1] <= '0;
                end
                count <= count - CNT_W'(1);
              end
            end
            default: begin
              if (32'(msel_q) >= NUM_METRICS) begin
                resp_status <= ST_ERR_NOTFOUND;
                out_list    <= '0;
              end else begin
                for (int unsigned i = 0; i < ENTRIES; i++)
                  out_list[i*SLOT_W +: SLOT_W] <=
                    (op_q == OP_READ_ALL ||
                     (met_list[msel_q][i].valid && mask_q[met_list[msel_q][i].id]))
                    ? met_list[msel_q][i] : '0;
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_smbm_param.sv
// Directed bench: default-size instance for ordering/filter/delete/handshake/reset,
// small 4-entry, 3-metric instance for capacity, duplicate and bad-msel cases.
module tb_smbm_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Instance A: defaults (256 entries, 8-bit IDs, 2 metrics)
  logic            a_valid = 1'b0, a_ready;
  logic [1:0]      a_op = '0;
  logic [7:0]      a_id = '0;
  logic [15:0]     a_met = '0;
  logic [255:0]    a_mask = '0;
  logic            a_msel = '0;
  logic            a_rv;
  logic [1:0]      a_st;
  logic [8:0]      a_count;
  logic [256*17-1:0] a_out;

  smbm_param u_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready),
    .req_op(a_op), .req_id(a_id), .req_metric(a_met), .req_mask(a_mask),
    .req_msel(a_msel), .resp_valid(a_rv), .resp_status(a_st),
    .count(a_count), .out_list(a_out)
  );

  // Instance B: 4 entries, 4-bit IDs, 3 metrics (msel is 2 bits, value 3 is out of range)
  logic            b_valid = 1'b0, b_ready;
  logic [1:0]      b_op = '0;
  logic [3:0]      b_id = '0;
  logic [23:0]     b_met = '0;
  logic [15:0]     b_mask = '0;
  logic [1:0]      b_msel = '0;
  logic            b_rv;
  logic [1:0]      b_st;
  logic [2:0]      b_count;
  logic [4*13-1:0] b_out;

  smbm_param #(.ENTRIES(4), .ID_W(4), .NUM_METRICS(3), .METRIC_W(8)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_op(b_op), .req_id(b_id), .req_metric(b_met), .req_mask(b_mask),
    .req_msel(b_msel), .resp_valid(b_rv), .resp_status(b_st),
    .count(b_count), .out_list(b_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] a_slot(input int i);
    return a_out[i*17 +: 17];
  endfunction

  function automatic logic [12:0] b_slot(input int i);
    return b_out[i*13 +: 13];
  endfunction

  // Fields are scrambled right after the accept edge to show they are sampled once.
  task automatic do_a(input logic [1:0] op, input logic [7:0] id, input logic [7:0] m0,
                      input logic [255:0] mask, input logic msel, output logic [1:0] st);
    @(negedge clk);
    chk("a_ready_pre", a_ready, 1'b1);
    a_valid = 1'b1; a_op = op; a_id = id; a_met = {8'd0, m0}; a_mask = mask; a_msel = msel;
    @(posedge clk); #1;
    a_valid = 1'b0; a_id = ~id; a_met = '1; a_mask = ~mask; a_msel = ~msel;
    @(negedge clk);
    @(negedge clk);
    chk("a_resp_early", a_rv, 1'b0);
    @(negedge clk);
    chk("a_resp_lat", a_rv, 1'b1);
    st = a_st;
  endtask

  task automatic do_b(input logic [1:0] op, input logic [3:0] id, input logic [7:0] m0,
                      input logic [1:0] msel, output logic [1:0] st);
    @(negedge clk);
    b_valid = 1'b1; b_op = op; b_id = id; b_met = {16'd0, m0}; b_mask = '1; b_msel = msel;
    @(posedge clk); #1;
    b_valid = 1'b0; b_id = ~id; b_met = '1; b_msel = ~msel;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("b_resp_lat", b_rv, 1'b1);
    st = b_st;
  endtask

  logic [1:0]   st;
  logic [255:0] m;
  logic         exp_ready [6];
  logic         exp_rv    [6];

  initial begin
    #12;
    chk("rst_count", a_count, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_resp", a_rv, 0);
    chk("rst_out0", a_slot(0), 0);
    @(negedge clk); rst = 1'b0;

    // Sorted insert with stable ties on metric 0
    do_a(2'd0, 8'd5, 8'd10, '0, 1'b0, st); chk("add5", st, 0);
    do_a(2'd0, 8'd2, 8'd10, '0, 1'b0, st); chk("add2", st, 0);
    do_a(2'd0, 8'd9, 8'd3,  '0, 1'b0, st); chk("add9", st, 0);
    chk("count3", a_count, 3);
    do_a(2'd3, 8'd0, 8'd0, '0, 1'b0, st); chk("rdall_st", st, 0);
    chk("rdall_s0", a_slot(0), 17'h10903);
    chk("rdall_s1", a_slot(1), 17'h1050A);
    chk("rdall_s2", a_slot(2), 17'h1020A);
    chk("rdall_s3", a_slot(3), 17'h0);
    do_a(2'd3, 8'd0, 8'd0, '0, 1'b1, st);
    chk("rdm1_s0", a_slot(0), 17'h10500);
    chk("rdm1_s1", a_slot(1), 17'h10200);
    chk("rdm1_s2", a_slot(2), 17'h10900);

    // Filter keeps slot positions, blanks rejected slots
    m = '0; m[2] = 1'b1; m[9] = 1'b1;
    do_a(2'd2, 8'd0, 8'd0, m, 1'b0, st); chk("filt_st", st, 0);
    chk("filt_s0", a_slot(0), 17'h10903);
    chk("filt_s1", a_slot(1), 17'h0);
    chk("filt_s2", a_slot(2), 17'h1020A);

    // Delete closes up every list
    do_a(2'd1, 8'd5, 8'd0, '0, 1'b0, st); chk("del5", st, 0);
    chk("count2", a_count, 2);
    chk("del_out_held", a_slot(1), 17'h0);
    do_a(2'd3, 8'd0, 8'd0, '0, 1'b0, st);
    chk("del_m0_s0", a_slot(0), 17'h10903);
    chk("del_m0_s1", a_slot(1), 17'h1020A);
    chk("del_m0_s2", a_slot(2), 17'h0);
    do_a(2'd3, 8'd0, 8'd0, '0, 1'b1, st);
    chk("del_m1_s0", a_slot(0), 17'h10200);
    chk("del_m1_s1", a_slot(1), 17'h10900);
    chk("del_m1_s2", a_slot(2), 17'h0);
    do_a(2'd1, 8'd5, 8'd0, '0, 1'b0, st); chk("del5_again", st, 3);
    chk("count2_keep", a_count, 2);
    do_a(2'd0, 8'd2, 8'd77, '0, 1'b0, st); chk("a_dup2", st, 2);
    chk("count2_dup", a_count, 2);

    // Back-to-back: req_valid held six cycles gives accepts at E0 and E3
    exp_ready = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_rv    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    a_valid = 1'b1; a_op = 2'd3; a_msel = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("hs_ready_%0d", k), a_ready, exp_ready[k]);
      @(negedge clk);
      chk($sformatf("hs_resp_%0d", k), a_rv, exp_rv[k]);
    end
    a_valid = 1'b0;
    chk("hs_ready_end", a_ready, 1);

    // Reset while an ADD is in EVAL
    @(negedge clk);
    a_valid = 1'b1; a_op = 2'd0; a_id = 8'd20; a_met = 16'd1;
    @(posedge clk); #1; a_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", a_count, 0);
    chk("mid_rst_s0", a_slot(0), 0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_rst_noresp_%0d", k), a_rv, 0);
      @(negedge clk);
    end
    chk("mid_rst_ready", a_ready, 1);
    chk("mid_rst_count2", a_count, 0);

    // Capacity, duplicates, out-of-range metric select on the small instance
    do_b(2'd0, 4'd1, 8'd40, 2'd0, st); chk("b_add1", st, 0);
    do_b(2'd0, 4'd2, 8'd30, 2'd0, st); chk("b_add2", st, 0);
    do_b(2'd0, 4'd3, 8'd20, 2'd0, st); chk("b_add3", st, 0);
    do_b(2'd0, 4'd4, 8'd10, 2'd0, st); chk("b_add4", st, 0);
    chk("b_count4", b_count, 4);
    do_b(2'd0, 4'd7, 8'd5, 2'd0, st); chk("b_full", st, 1);
    chk("b_count_full", b_count, 4);
    do_b(2'd0, 4'd3, 8'd5, 2'd0, st); chk("b_dup", st, 2);
    chk("b_count_dup", b_count, 4);
    do_b(2'd3, 4'd0, 8'd0, 2'd0, st); chk("b_rd_st", st, 0);
    chk("b_rd_s0", b_slot(0), 13'h140A);
    chk("b_rd_s1", b_slot(1), 13'h1314);
    chk("b_rd_s2", b_slot(2), 13'h121E);
    chk("b_rd_s3", b_slot(3), 13'h1128);
    do_b(2'd3, 4'd0, 8'd0, 2'd3, st); chk("b_badsel_st", st, 3);
    chk("b_badsel_out", b_out, 0);
    do_b(2'd1, 4'd4, 8'd0, 2'd0, st); chk("b_del4", st, 0);
    chk("b_count3", b_count, 3);
    do_b(2'd0, 4'd7, 8'd5, 2'd0, st); chk("b_add7", st, 0);
    do_b(2'd3, 4'd0, 8'd0, 2'd0, st);
    chk("b_rd2_s0", b_slot(0), 13'h1705);
    chk("b_rd2_s1", b_slot(1), 13'h1314);
    chk("b_rd2_s2", b_slot(2), 13'h121E);
    chk("b_rd2_s3", b_slot(3), 13'h1128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/smbm_param.md
# smbm_param

Parametrised sorted multi-metric bookkeeping block, successor to the fixed 256-entry manager. It holds up to ENTRIES live IDs. Each ID carries NUM_METRICS metric values. It keeps one ID-sorted list plus one value-sorted list per metric, and serves ADD, DELETE and filtered or unfiltered READ requests over a valid/ready request port with a status-bearing response. Compared with the previous generation it adds:

- per-slot valid bits instead of value sentinels
- stable tie ordering
- duplicate and full detection
- an occupancy count
- a handshake in place of the free-running opcode

## Interface
Parameters:
- ENTRIES, 256: list depth; power of two ≥ 2
- ID_W, 8: ID width; ID space is 2**ID_W
- NUM_METRICS, 2: number of metric lists
- METRIC_W, 8: metric value width
- MSEL_W, $clog2(NUM_METRICS) (min 1): metric-select width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block idle; request accepted on clk edge with req_valid && req_ready
- req_op  in  2  0 ADD, 1 DELETE, 2 READ_FILT, 3 READ_ALL
- req_id  in  ID_W  ID for ADD/DELETE
- req_metric  in  NUM_METRICS×METRIC_W  metric values for ADD
- req_mask  in  2**ID_W  READ_FILT filter, indexed by ID
- req_msel  in  MSEL_W  metric list for READ
- resp_valid  out  1  one-cycle response strobe
- resp_status  out  2  0 OK, 1 ERR_FULL, 2 ERR_DUP, 3 ERR_NOTFOUND
- count  out  $clog2(ENTRIES)+1  live entries
- out_list  out  ENTRIES×(1+ID_W+METRIC_W)  READ result; slot i = {valid, id, val}, slot 0 = smallest

## Operation
- **Storage.**
  - ID list: ENTRIES slots of {valid, id}, ascending by id, valid slots packed at 0..count-1.
  - Each metric list: slots of {valid, id, val}, ascending by val, packed.
  - Metric slots store the owning ID, not a position, so nothing goes stale on shifts.
- **Compare rule.** Slot is "greater" iff !valid or stored key > request key. A priority encoder over this bit vector gives the insertion index, so equal values insert after existing ones (stable).
- **ADD.**
  - ID already present → ERR_DUP.
  - Else count==ENTRIES → ERR_FULL.
  - Else insert into the ID list and each metric list at its encoder index, shift higher slots up one, count+1, status OK.
- **DELETE.**
  - ID absent → ERR_NOTFOUND.
  - Else locate the ID in every list by equality match, remove it, shift higher slots down one, clear the top slot to invalid, count-1, status OK.
- **READ_FILT.** Slot i of the selected list is copied to out_list[i] if valid && req_mask[id]; otherwise out_list[i] = all-zero (valid=0). No compaction.
- **READ_ALL.** Selected list copied verbatim.
- **READ with req_msel ≥ NUM_METRICS.** ERR_NOTFOUND, out_list all-zero.
- **Error cases.** Any error leaves lists and count unchanged. out_list changes only on READ.
- **FSM.** IDLE → EVAL → COMMIT → IDLE.
  - IDLE: req_ready=1.
  - EVAL: compare vectors evaluated, encoder indices and match flags registered.
  - COMMIT: lists and out_list written; resp_valid/resp_status registered.

## Timing
- **Reset.** Async; takes effect immediately.
  - State IDLE, all slots invalid/zero, count=0, out_list all-zero, resp_valid=0, resp_status=0.
  - An in-flight op is dropped with no response.
- **Latency.** Request accepted at edge E0 → resp_valid high for exactly the cycle after edge E2. Results visible in that same cycle.
- **Throughput.** req_ready is 1 again after E2, so the next accept is at E3 at the earliest, which also clears resp_valid. One op per 3 cycles.
- **Request stability.** Request fields are sampled at E0 only and need not be held.
- **No backpressure.** The response does not wait for a consumer.
- **count.** Updates at E2 of ADD/DELETE.

## Structure
- Package smbm_pkg: op enum, status enum, default parameter constants.
- Entry structs are built from the module parameters as local packed typedefs.
- Reuse the existing priority_encode_log sub-module. Instantiate one per list (NUM_METRICS+1), width ENTRIES.

## Test plan
- **Sorted insert, stable ties.** Defaults; ADD id 5 {m0=10}, id 2 {m0=10}, id 9 {m0=3} → each OK, count=3. READ_ALL msel 0 → out_list[0..2] = {1,9,3},{1,5,10},{1,2,10}, slot 3 valid=0.
- **Filter.** Same state; READ_FILT msel 0, mask bits {2,9} set → slots 0 and 2 valid, slot 1 all-zero.
- **Delete.** DELETE 5 → OK, count=2, all lists closed up. DELETE 5 again → ERR_NOTFOUND, count=2.
- **Capacity and duplicates.** ENTRIES=4, ID_W=4:
  - ADD ids 1..4 → OK.
  - ADD 7 → ERR_FULL.
  - ADD 3 → ERR_DUP.
  - count=4 throughout the two error cases.
- **Handshake and latency.** req_valid held high for 6 cycles → accepts exactly at E0 and E3. resp_valid pulses after E2 and after E5. req_ready low between accepts.
- **Reset mid-operation.** Assert rst during EVAL of an ADD → no resp_valid, count=0, out_list zero, req_ready=1 after rst releases.
